uart_tx_ctrl: RTL

Sequencing controller for the UART transmitter output multiplexer. It accepts a parallel word with a valid strobe and latches the word and the parity configuration. It then steps the multiplexer select through start, data (LSB first), optional parity and stop, supplying the serial data bit and parity bit the multiplexer forwards to the TX line. It runs on the TX bit clock, one bit per clock cycle, and sits directly between the UART_TX top-level inputs and the TX multiplexer.

---
 rtl/uart_tx_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl
// Sequencing controller for the UART transmitter output multiplexer.
// A word is accepted with Data_Valid while idle (or during the stop bit, for
// back-to-back frames). The controller then walks the mux select through
// start, DATA_WIDTH data bits (LSB first), an optional parity bit and one stop
// bit, one bit per CLK cycle.
//
// Ports:
//   CLK          TX bit clock, one serial bit per cycle
//   RST          asynchronous, active-low reset
//   P_DATA       parallel word to transmit
//   Data_Valid   P_DATA valid this cycle (pulse or level)
//   PAR_EN       1 = frame carries a parity bit
//   PAR_TYP      0 = even parity, 1 = odd parity
//   MUX_SEL      00 start, 01 stop/idle, 10 serial data, 11 parity
//   MUX_ser_data current data bit (LSB of the shift register)
//   MUX_par_bit  parity bit of the latched word
//   busy         high while a frame is in progress
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [1:0]            MUX_SEL,
    output logic                  MUX_ser_data,
    output logic                  MUX_par_bit,
    output logic                  busy
);

    localparam int              CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                  state_reg;
    state_t                  state_next;
    logic [DATA_WIDTH-1:0]   data_sr_reg;
    logic [DATA_WIDTH-1:0]   data_sr_shifted;
    logic [CNT_W-1:0]        bit_cnt_reg;
    logic                    par_en_reg;
    logic                    par_bit_reg;
    logic                    accept;

    // A new word is only taken when no frame is occupying the line, or in the
    // final stop cycle so consecutive frames run without an idle gap.
    assign accept = Data_Valid && ((state_reg == IDLE) || (state_reg == STOP));

    // Right shift with zero fill: the next data bit moves into the LSB.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH - 1; gi++) begin : g_shift
            assign data_sr_shifted[gi] = data_sr_reg[gi + 1];
        end
    endgenerate
    assign data_sr_shifted[DATA_WIDTH-1] = 1'b0;

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = START;
            START:   state_next = DATA;
            DATA:    if (bit_cnt_reg == LAST_BIT) state_next = par_en_reg ? PARITY : STOP;
            PARITY:  state_next = STOP;
            STOP:    state_next = accept ? START : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Moore outputs decoded from the registered state
    always_comb begin
        MUX_SEL = 2'b01;
        case (state_reg)
            START:   MUX_SEL = 2'b00;
            DATA:    MUX_SEL = 2'b10;
            PARITY:  MUX_SEL = 2'b11;
            default: MUX_SEL = 2'b01;
        endcase
    end

    assign busy         = (state_reg != IDLE);
    assign MUX_ser_data = data_sr_reg[0];
    assign MUX_par_bit  = par_bit_reg;

    // Datapath: word/parity latch, shift register and bit counter
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            data_sr_reg <= '0;
            bit_cnt_reg <= '0;
            par_en_reg  <= 1'b0;
            par_bit_reg <= 1'b0;
        end else begin
            if (accept) begin
                data_sr_reg <= P_DATA;
                par_en_reg  <= PAR_EN;
                par_bit_reg <= (^P_DATA) ^ PAR_TYP;
            end else if (state_reg == DATA) begin
                data_sr_reg <= data_sr_shifted;
            end

            // Counter holds at the last index on the way out of DATA so it
            // never wraps, even when DATA_WIDTH is a power of two.
            if (state_reg == START) begin
                bit_cnt_reg <= '0;
            end else if ((state_reg == DATA) && (bit_cnt_reg != LAST_BIT)) begin
                bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
            end
        end
    end

endmodule
